lcd_frame_writer: RTL and testbench
===================================

// Module: lcd_frame_writer
// PURPOSE
//  Sequences the ST7789V3 memory-write phase once the init sequence completes.
//  Issues CASET/RASET windowing and RAMWR, then streams RGB565 pixels as byte pairs.
//  Writes 9-bit words into the serdes FIFO write port; bit 8 is the RS flag.
//  Word encoding: bit 8 = 1 for data, 0 for command.
//  Started by the top-level driver in its WRMEM state; one start produces one window write.
// PARAMETERS
//  H_RES       240  panel columns; x1 must be < H_RES
//  V_RES       280  panel rows; y1 must be < V_RES
//  X_OFFSET    0    column offset added to x0/x1 before CASET
//  Y_OFFSET    20   row offset added to y0/y1 before RASET
//  COORD_WIDTH 9    width of window coordinate inputs
//  WORD_WIDTH  9    FIFO word width; fixed at 9
// PORTS
//  clk       in   1            clock
//  rst       in   1            asynchronous reset, active-low
//  start     in   1            begin window write; sampled only in IDLE
//  x0,x1     in   COORD_WIDTH  inclusive column bounds; latched on accepted start
//  y0,y1     in   COORD_WIDTH  inclusive row bounds; latched on accepted start
//  busy      out  1            high from accepted start until done/err
//  done      out  1            1-cycle pulse after the last pixel byte is accepted
//  err       out  1            1-cycle pulse when a window is rejected
//  px_valid  in   1            pixel source valid
//  px_ready  out  1            pixel accepted when px_valid && px_ready
//  px_data   in   16           RGB565 pixel
//  wr_valid  out  1            FIFO write valid; registered output
//  wr_ready  in   1            FIFO not full
//  wr_data   out  WORD_WIDTH   FIFO word; registered output
// BEHAVIOUR
//  Reset values: busy=0, done=0, err=0, px_ready=0, wr_valid=0, wr_data=0; state=IDLE.
//  Reset is asynchronous and mid-operation: the window is abandoned, nothing is flushed,
//   and the block returns to IDLE.
//  Transfer rule: a word transfers on wr_valid && wr_ready.
//   While wr_valid=1 and wr_ready=0, wr_data is held stable.
//   wr_valid never drops without a transfer.
//  The output register is "free" when !wr_valid || wr_ready.
//   Each free cycle loads the next word, so commands/args flow at 1 word/clk.
//  States:
//   IDLE -> CASET on start && window valid; window latched, busy=1.
//   CASET: cmd 0x02A, then 0x100|XS[15:8], XS[7:0], XE[15:8], XE[7:0].
//    XS = x0+X_OFFSET, XE = x1+X_OFFSET, both 16-bit.
//   RASET: cmd 0x02B, then 4 args built the same way from Y_OFFSET.
//   RAMWR: cmd 0x02C; pixel counter loaded with (x1-x0+1)*(y1-y0+1), 17-bit.
//   PIX: px_ready = free && !lo_pending.
//    On pixel accept: load 0x100|px_data[15:8] and store the low byte (lo_pending=1).
//    On the next free cycle: load 0x100|lo and decrement the counter.
//    Peak rate: 1 pixel / 2 clk.
//   DRAIN: wait for the final word to transfer, pulse done, clear busy -> IDLE.
//  Argument index is a 2-bit counter that wraps at 3.
//  Pixel counter: when it reaches 0 after the low byte is loaded, go to DRAIN; px_ready=0 from then on.
//  Window invalid if any of: x1<x0, y1<y0, x1>=H_RES, y1>=V_RES.
//   Result: err pulses in the cycle after start, no words are written, stays IDLE.
//  start while busy is ignored; x/y inputs are ignored except in the start-accept cycle.
//  px_valid gaps insert bubbles, not errors; px_data is sampled only on accept.
//  First wr_valid appears 1 clk after start is accepted.
// TESTING
//  Window (0,0)-(0,0), px 0xF800, wr_ready=1 -> exact words:
//   02A,100,100,100,100,02B,100,114,100,114,02C,1F8,100; done 1 pulse; busy low after.
//  Full frame (0,0)-(239,279), random px, wr_ready=1 -> 11+134400 words;
//   last word = 0x100|lo of final pixel; exactly 67200 px handshakes.
//  Window (10,5)-(12,6), wr_ready random 50% -> same word stream as with wr_ready=1;
//   wr_data stable while stalled; 6 pixels.
//  Window x0=5, x1=4 -> err pulse, wr_valid stays 0, busy stays 0;
//   a following valid start then works.
//  px_valid low for 20 clk mid-frame -> no extra words;
//   stream resumes and is correct; start pulsed while busy has no effect.
//  rst asserted during PIX -> wr_valid/px_ready/busy = 0 immediately;
//   a new start after release produces a full CASET-led sequence.

Source files
------------

// File: rtl/lcd_frame_writer.sv
// ST7789V3 memory-write sequencer: emits CASET/RASET/RAMWR and then streams
// RGB565 pixels as two data bytes each into a 9-bit command/data FIFO.
module lcd_frame_writer #(
    parameter int H_RES       = 240,
    parameter int V_RES       = 280,
    parameter int X_OFFSET    = 0,
    parameter int Y_OFFSET    = 20,
    parameter int COORD_WIDTH = 9,
    parameter int WORD_WIDTH  = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] x0,
    input  logic [COORD_WIDTH-1:0] x1,
    input  logic [COORD_WIDTH-1:0] y0,
    input  logic [COORD_WIDTH-1:0] y1,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   px_valid,
    output logic                   px_ready,
    input  logic [15:0]            px_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [WORD_WIDTH-1:0]  wr_data
);

    localparam logic [8:0]  CMD_CASET = 9'h02A;
    localparam logic [8:0]  CMD_RASET = 9'h02B;
    localparam logic [8:0]  CMD_RAMWR = 9'h02C;
    localparam logic [31:0] H_LIM     = 32'(H_RES);
    localparam logic [31:0] V_LIM     = 32'(V_RES);
    localparam logic [15:0] X_OFF     = 16'(X_OFFSET);
    localparam logic [15:0] Y_OFF     = 16'(Y_OFFSET);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_PIX,
        S_DRAIN
    } state_t;

    state_t      state_r;
    logic [15:0] xs_r;
    logic [15:0] xe_r;
    logic [15:0] ys_r;
    logic [15:0] ye_r;
    logic [16:0] cnt_r;
    logic [1:0]  idx_r;
    logic        cmd_sent_r;
    logic [7:0]  lo_r;
    logic        lo_pending_r;

    logic        free_s;
    logic        win_ok_s;
    logic [16:0] wdt_s;
    logic [16:0] hgt_s;
    logic [16:0] area_s;

    // Window arguments go out high byte first: start, then end coordinate.
    function automatic logic [8:0] arg_word(input logic [15:0] s, input logic [15:0] e,
                                            input logic [1:0] idx);
        logic [8:0] w;
        case (idx)
            2'd0:    w = {1'b1, s[15:8]};
            2'd1:    w = {1'b1, s[7:0]};
            2'd2:    w = {1'b1, e[15:8]};
            default: w = {1'b1, e[7:0]};
        endcase
        return w;
    endfunction

    // Handshake qualifiers, window check and pixel count of the latched window.
    always_comb begin
        free_s   = !wr_valid || wr_ready;
        win_ok_s = (x1 >= x0) && (y1 >= y0) &&
                   (32'(x1) < H_LIM) && (32'(y1) < V_LIM);
        wdt_s    = 17'(xe_r - xs_r) + 17'd1;
        hgt_s    = 17'(ye_r - ys_r) + 17'd1;
        area_s   = wdt_s * hgt_s;
        px_ready = (state_r == S_PIX) && free_s && !lo_pending_r;
    end

    // Sequencer: one word loaded into the output register per free cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            xs_r         <= 16'd0;
            xe_r         <= 16'd0;
            ys_r         <= 16'd0;
            ye_r         <= 16'd0;
            cnt_r        <= 17'd0;
            idx_r        <= 2'd0;
            cmd_sent_r   <= 1'b0;
            lo_r         <= 8'd0;
            lo_pending_r <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            wr_valid     <= 1'b0;
            wr_data      <= 9'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        if (win_ok_s) begin
                            xs_r       <= 16'(x0) + X_OFF;
                            xe_r       <= 16'(x1) + X_OFF;
                            ys_r       <= 16'(y0) + Y_OFF;
                            ye_r       <= 16'(y1) + Y_OFF;
                            idx_r      <= 2'd0;
                            cmd_sent_r <= 1'b0;
                            busy       <= 1'b1;
                            wr_valid   <= 1'b1;
                            wr_data    <= CMD_CASET;
                            state_r    <= S_CASET;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_CASET: begin
                    if (free_s) begin
                        wr_valid <= 1'b1;
                        wr_data  <= arg_word(xs_r, xe_r, idx_r);
                        idx_r    <= idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            cmd_sent_r <= 1'b0;
                            state_r    <= S_RASET;
                        end
                    end
                end
                S_RASET: begin
                    if (free_s) begin
                        wr_valid <= 1'b1;
                        if (!cmd_sent_r) begin
                            wr_data    <= CMD_RASET;
                            cmd_sent_r <= 1'b1;
                        end else begin
                            wr_data <= arg_word(ys_r, ye_r, idx_r);
                            idx_r   <= idx_r + 2'd1;
                            if (idx_r == 2'd3) begin
                                state_r <= S_RAMWR;
                            end
                        end
                    end
                end
                S_RAMWR: begin
                    if (free_s) begin
                        wr_valid <= 1'b1;
                        wr_data  <= CMD_RAMWR;
                        cnt_r    <= area_s;
                        state_r  <= S_PIX;
                    end
                end
                S_PIX: begin
                    // The low byte of a pixel has priority; px_ready is held off meanwhile.
                    if (lo_pending_r && free_s) begin
                        wr_valid     <= 1'b1;
                        wr_data      <= {1'b1, lo_r};
                        lo_pending_r <= 1'b0;
                        cnt_r        <= cnt_r - 17'd1;
                        if (cnt_r == 17'd1) begin
                            state_r <= S_DRAIN;
                        end
                    end else if (px_valid && px_ready) begin
                        wr_valid     <= 1'b1;
                        wr_data      <= {1'b1, px_data[15:8]};
                        lo_r         <= px_data[7:0];
                        lo_pending_r <= 1'b1;
                    end else if (free_s) begin
                        wr_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (free_s) begin
                        wr_valid <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomized bench for lcd_frame_writer: a queue-based model of the expected
// word stream is compared with the words the FIFO port actually accepts.
module tb_lcd_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  x0 = 9'd0, x1 = 9'd0, y0 = 9'd0, y1 = 9'd0;
    logic        busy, done, err;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [15:0] px_data = 16'd0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [8:0]  wr_data;

    lcd_frame_writer dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .busy(busy), .done(done), .err(err),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // written by the monitor only
    logic [8:0] got_q[$];
    int px_idx = 0, done_cnt = 0, err_cnt = 0, wv_cnt = 0, busy_cnt = 0;
    int stall_seen = 0, stall_viol = 0;
    bit held = 1'b0;
    logic [8:0] held_data = 9'd0;

    // written by the tasks only
    logic [15:0] pix_q[$];
    logic [8:0]  exp_q[$];
    int px_base = 0, gap_pos = -1, gap_tag = 0;
    bit src_en = 1'b0, stall_en = 1'b0, vrand_en = 1'b0;

    // written by the driver only
    int gap_cnt = 0, seen_tag = 0;

    // per-window results
    logic [8:0] res_words[$];
    int  res_hs, res_done, res_err, res_wv, res_busy, res_sv, res_ss, n_bad, first_bad;
    bit  res_timeout, res_busy_end, first_wv, first_err, first_busy;
    logic [8:0] first_data;
    bit  ab_wv, ab_pr, ab_busy;

    // Input driver: changes FIFO readiness and the pixel source just after each rising edge.
    always @(posedge clk) begin : drv
        int rel;
        #1;
        wr_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (gap_tag != seen_tag) begin
            seen_tag = gap_tag;
            gap_cnt  = 0;
        end
        rel = px_idx - px_base;
        if (src_en && rel < pix_q.size()) begin
            if (gap_pos >= 0 && rel == gap_pos && gap_cnt < 20) begin
                px_valid = 1'b0;
                gap_cnt++;
            end else if (vrand_en && $urandom_range(0, 3) == 0) begin
                px_valid = 1'b0;
            end else begin
                px_valid = 1'b1;
                px_data  = pix_q[rel];
            end
        end else begin
            px_valid = 1'b0;
        end
    end

    // Monitor: samples handshakes on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_valid && wr_ready) got_q.push_back(wr_data);
            if (wr_valid) wv_cnt++;
            if (busy) busy_cnt++;
            if (px_valid && px_ready) px_idx++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (held) begin
                stall_seen++;
                if (!wr_valid || wr_data !== held_data) stall_viol++;
            end
            held      = wr_valid && !wr_ready;
            held_data = wr_data;
        end else begin
            held = 1'b0;
        end
    end

    task automatic do_window(input int ax0, input int ay0, input int ax1, input int ay1,
                             input int fixed_px, input bit stall, input bit vrand,
                             input int gap, input int poke_at, input int abort_at);
        bit ok;
        int area, budget, b_got, b_done, b_err, b_hs, b_wv, b_busy, b_sv, b_ss;
        logic [15:0] p, v;
        ok = (ax1 >= ax0) && (ay1 >= ay0) && (ax1 < 240) && (ay1 < 280);
        pix_q.delete();
        exp_q.delete();
        if (ok) begin
            area = (ax1 - ax0 + 1) * (ay1 - ay0 + 1);
            for (int i = 0; i < area; i++) begin
                p = (fixed_px >= 0) ? 16'(fixed_px) : 16'($urandom);
                pix_q.push_back(p);
            end
            exp_q.push_back(9'h02A);
            v = 16'(ax0); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
            v = 16'(ax1); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
            exp_q.push_back(9'h02B);
            v = 16'(ay0 + 20); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
            v = 16'(ay1 + 20); exp_q.push_back({1'b1, v[15:8]}); exp_q.push_back({1'b1, v[7:0]});
            exp_q.push_back(9'h02C);
            foreach (pix_q[i]) begin
                v = pix_q[i];
                exp_q.push_back({1'b1, v[15:8]});
                exp_q.push_back({1'b1, v[7:0]});
            end
        end
        b_got = got_q.size(); b_done = done_cnt; b_err = err_cnt; b_hs = px_idx;
        b_wv = wv_cnt; b_busy = busy_cnt; b_sv = stall_viol; b_ss = stall_seen;
        px_base = px_idx; gap_pos = gap; stall_en = stall; vrand_en = vrand;
        gap_tag++; src_en = 1'b1;
        @(posedge clk); #1;
        x0 = 9'(ax0); y0 = 9'(ay0); x1 = 9'(ax1); y1 = 9'(ay1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first_wv = wr_valid; first_err = err; first_busy = busy; first_data = wr_data;
        x0 = 9'($urandom); y0 = 9'($urandom); x1 = 9'($urandom); y1 = 9'($urandom);
        budget = 8 * exp_q.size() + 400;
        res_timeout = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!ok && n >= 10) break;
            if (ok && done_cnt != b_done) break;
            if (poke_at > 0 && n == poke_at) begin
                start = 1'b1; x0 = 9'd0; y0 = 9'd0; x1 = 9'd0; y1 = 9'd0;
            end
            if (poke_at > 0 && n == poke_at + 1) start = 1'b0;
            if (abort_at > 0 && n == abort_at) begin
                #2 rst = 1'b0;
                #1 ab_wv = wr_valid; ab_pr = px_ready; ab_busy = busy;
                #20 rst = 1'b1;
                break;
            end
            if (n == budget - 1) res_timeout = 1'b1;
        end
        repeat (3) @(negedge clk);
        src_en = 1'b0; stall_en = 1'b0; vrand_en = 1'b0; gap_pos = -1;
        res_words.delete();
        for (int i = b_got; i < got_q.size(); i++) res_words.push_back(got_q[i]);
        res_hs = px_idx - b_hs; res_done = done_cnt - b_done; res_err = err_cnt - b_err;
        res_wv = wv_cnt - b_wv; res_busy = busy_cnt - b_busy;
        res_sv = stall_viol - b_sv; res_ss = stall_seen - b_ss;
        res_busy_end = busy;
        n_bad = 0; first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < res_words.size(); i++) begin
            if (res_words[i] !== exp_q[i]) begin
                n_bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
    endtask

    task automatic test_reset();
        #7;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (px_ready !== 1'b0) begin failures++; $display("FAIL reset_px_ready got=%b want=0", px_ready); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b want=0", wr_valid); end
        checks++; if (wr_data !== 9'd0) begin failures++; $display("FAIL reset_wr_data got=%h want=000", wr_data); end
        #16 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset wr_valid=%b busy=%b want 0/0", wr_valid, busy);
        end
    endtask

    task automatic test_single_pixel();
        logic [8:0] lit [0:12];
        int bad;
        lit = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100, 9'h114,
                9'h100, 9'h114, 9'h02C, 9'h1F8, 9'h100};
        do_window(0, 0, 0, 0, 16'hF800, 1'b0, 1'b0, -1, 0, 0);
        checks++; if (first_wv !== 1'b1 || first_data !== 9'h02A || first_busy !== 1'b1) begin
            failures++; $display("FAIL single_first_word valid=%b data=%h busy=%b want 1/02A/1", first_wv, first_data, first_busy);
        end
        checks++; if (res_words.size() !== 13) begin
            failures++; $display("FAIL single_len got=%0d want=13", res_words.size());
        end
        bad = 0;
        for (int i = 0; i < 13 && i < res_words.size(); i++) if (res_words[i] !== lit[i]) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL single_words mismatched=%0d want=0", bad); end
        checks++; if (res_done !== 1 || res_busy_end !== 1'b0) begin
            failures++; $display("FAIL single_done pulses=%0d busy=%b want 1/0", res_done, res_busy_end);
        end
    endtask

    task automatic test_random_windows();
        int ax0, ax1, ay0, ay1;
        for (int k = 0; k < 4; k++) begin
            ax0 = $urandom_range(0, 239); ax1 = $urandom_range(ax0, (ax0 + 7 > 239) ? 239 : ax0 + 7);
            ay0 = $urandom_range(0, 279); ay1 = $urandom_range(ay0, (ay0 + 5 > 279) ? 279 : ay0 + 5);
            do_window(ax0, ay0, ax1, ay1, -1, 1'b0, 1'b0, -1, 0, 0);
            checks++; if (res_timeout || res_words.size() !== exp_q.size() || n_bad !== 0) begin
                failures++; $display("FAIL rand_stream win=%0d len=%0d want=%0d bad=%0d first=%0d", k, res_words.size(), exp_q.size(), n_bad, first_bad);
            end
            checks++; if (res_hs !== pix_q.size() || res_done !== 1 || res_busy_end !== 1'b0) begin
                failures++; $display("FAIL rand_handshake win=%0d px=%0d want=%0d done=%0d busy=%b", k, res_hs, pix_q.size(), res_done, res_busy_end);
            end
        end
    endtask

    task automatic test_stall();
        do_window(10, 5, 12, 6, -1, 1'b1, 1'b1, -1, 0, 0);
        checks++; if (res_timeout || res_words.size() !== exp_q.size() || n_bad !== 0) begin
            failures++; $display("FAIL stall_stream len=%0d want=%0d bad=%0d first=%0d", res_words.size(), exp_q.size(), n_bad, first_bad);
        end
        checks++; if (res_hs !== 6 || res_done !== 1) begin
            failures++; $display("FAIL stall_pixels px=%0d want=6 done=%0d want=1", res_hs, res_done);
        end
        checks++; if (res_ss == 0 || res_sv !== 0) begin
            failures++; $display("FAIL stall_hold stalls=%0d violations=%0d want >0/0", res_ss, res_sv);
        end
    endtask

    task automatic test_invalid();
        int cases [0:3][0:3];
        cases = '{'{5, 0, 4, 0}, '{0, 0, 240, 0}, '{0, 0, 0, 280}, '{0, 5, 0, 4}};
        for (int k = 0; k < 4; k++) begin
            do_window(cases[k][0], cases[k][1], cases[k][2], cases[k][3], -1, 1'b0, 1'b0, -1, 0, 0);
            checks++; if (first_err !== 1'b1 || res_err !== 1) begin
                failures++; $display("FAIL invalid_err case=%0d err_now=%b pulses=%0d want 1/1", k, first_err, res_err);
            end
            checks++; if (res_wv !== 0 || res_busy !== 0 || res_words.size() !== 0) begin
                failures++; $display("FAIL invalid_quiet case=%0d wv=%0d busy=%0d words=%0d want 0/0/0", k, res_wv, res_busy, res_words.size());
            end
        end
        do_window(3, 3, 4, 4, -1, 1'b0, 1'b0, -1, 0, 0);
        checks++; if (res_timeout || res_words.size() !== exp_q.size() || n_bad !== 0 || res_err !== 0) begin
            failures++; $display("FAIL after_invalid len=%0d want=%0d bad=%0d err=%0d", res_words.size(), exp_q.size(), n_bad, res_err);
        end
    endtask

    task automatic test_gap_and_busy_start();
        do_window(0, 0, 9, 4, -1, 1'b0, 1'b0, 10, 40, 0);
        checks++; if (gap_cnt !== 20) begin
            failures++; $display("FAIL gap_applied got=%0d want=20", gap_cnt);
        end
        checks++; if (res_timeout || res_words.size() !== exp_q.size() || n_bad !== 0) begin
            failures++; $display("FAIL gap_stream len=%0d want=%0d bad=%0d first=%0d", res_words.size(), exp_q.size(), n_bad, first_bad);
        end
        checks++; if (res_hs !== 50 || res_done !== 1 || res_busy_end !== 1'b0) begin
            failures++; $display("FAIL busy_start_ignored px=%0d want=50 done=%0d busy=%b", res_hs, res_done, res_busy_end);
        end
    endtask

    task automatic test_reset_mid();
        do_window(10, 10, 29, 29, -1, 1'b0, 1'b0, -1, 0, 60);
        checks++; if (res_hs == 0) begin
            failures++; $display("FAIL abort_in_pix px=%0d want >0", res_hs);
        end
        checks++; if (ab_wv !== 1'b0 || ab_pr !== 1'b0 || ab_busy !== 1'b0) begin
            failures++; $display("FAIL async_reset wr_valid=%b px_ready=%b busy=%b want 0/0/0", ab_wv, ab_pr, ab_busy);
        end
        do_window(1, 2, 3, 4, -1, 1'b1, 1'b0, -1, 0, 0);
        checks++; if (res_timeout || res_words.size() !== exp_q.size() || n_bad !== 0) begin
            failures++; $display("FAIL restart_stream len=%0d want=%0d bad=%0d first=%0d", res_words.size(), exp_q.size(), n_bad, first_bad);
        end
    endtask

    task automatic test_large_corner();
        do_window(200, 250, 239, 279, -1, 1'b0, 1'b0, -1, 0, 0);
        checks++; if (res_timeout || res_words.size() !== 11 + 2400 || n_bad !== 0) begin
            failures++; $display("FAIL corner_stream len=%0d want=2411 bad=%0d first=%0d", res_words.size(), n_bad, first_bad);
        end
        checks++; if (res_words.size() > 0 && res_words[res_words.size() - 1] !== {1'b1, pix_q[pix_q.size() - 1][7:0]}) begin
            failures++; $display("FAIL corner_last got=%h want=%h", res_words[res_words.size() - 1], {1'b1, pix_q[pix_q.size() - 1][7:0]});
        end
        checks++; if (res_hs !== 1200 || res_done !== 1) begin
            failures++; $display("FAIL corner_pixels px=%0d want=1200 done=%0d", res_hs, res_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_random_windows();
        test_stall();
        test_invalid();
        test_gap_and_busy_start();
        test_reset_mid();
        test_large_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
